// File: rtl/connect4_board_judge.sv
// connect4_board_judge
// Board keeper and referee for Connect4. Takes a column drop request from the
// current player, stacks the piece in the lowest free row, then scans the four
// lines through that piece (one direction per cycle) for four-in-a-row and
// reports the result.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   new_game              synchronous clear, aborts any move in flight
//   move_valid, move_col  drop request (sampled only in IDLE)
//   busy                  move in progress
//   move_ack, move_reject one-cycle result pulses
//   player_turn           player to move
//   game_status           00 playing, 01 P0 wins, 10 P1 wins, 11 draw
//   rd_row, rd_col        display read address
//   rd_cell               combinational cell read (00 when out of range)

module connect4_board_judge #(
    parameter int unsigned ROWS = 6,
    parameter int unsigned COLS = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [2:0] move_col,
    output logic       busy,
    output logic       move_ack,
    output logic       move_reject,
    output logic       player_turn,
    output logic [1:0] game_status,
    input  logic [2:0] rd_row,
    input  logic [2:0] rd_col,
    output logic [1:0] rd_cell
);

    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned HW    = $clog2(ROWS + 1);
    localparam int unsigned MW    = $clog2(CELLS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DROP   = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    logic [1:0]                     state_q,  state_d;
    logic [ROWS-1:0][COLS-1:0][1:0] board_q,  board_d;
    logic [COLS-1:0][HW-1:0]        height_q, height_d;
    logic [MW-1:0]                  moves_q,  moves_d;
    logic [2:0]                     col_q,    col_d;
    logic [2:0]                     row_q,    row_d;
    logic                           mover_q,  mover_d;
    logic [1:0]                     dir_q,    dir_d;
    logic                           win_q,    win_d;
    logic                           rej_q,    rej_d;
    logic                           busy_q,   busy_d;
    logic                           ack_q,    ack_d;
    logic                           reject_q, reject_d;
    logic                           turn_q,   turn_d;
    logic [1:0]                     status_q, status_d;

    logic          col_ok_c;
    logic          col_full_c;
    logic [HW-1:0] cur_height_c;
    logic [1:0]    mover_code_c;
    int            run_cnt_c;

    // Length of the same-player line through (r0,c0) along (dr,dc), both ways,
    // at most 3 cells each way, stopping at the board edge.
    function automatic int line_len(
        input logic [ROWS-1:0][COLS-1:0][1:0] brd,
        input int r0,
        input int c0,
        input int dr,
        input int dc,
        input logic [1:0] code
    );
        int  cnt;
        int  r;
        int  c;
        int  sgn;
        logic alive;
        cnt = 1;
        for (int s = 0; s < 2; s++) begin
            sgn   = (s == 0) ? 1 : -1;
            alive = 1'b1;
            for (int k = 1; k <= 3; k++) begin
                r = r0 + sgn * k * dr;
                c = c0 + sgn * k * dc;
                if (alive && r >= 0 && r < int'(ROWS) && c >= 0 && c < int'(COLS)) begin
                    if (brd[r][c] == code) begin
                        cnt = cnt + 1;
                    end else begin
                        alive = 1'b0;
                    end
                end else begin
                    alive = 1'b0;
                end
            end
        end
        return cnt;
    endfunction

    // Height of the latched column and whether the drop is legal.
    always_comb begin
        cur_height_c = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            if (3'(c) == col_q) begin
                cur_height_c = height_q[c];
            end
        end
        col_ok_c     = ({1'b0, col_q} < 4'(COLS));
        col_full_c   = (cur_height_c == HW'(ROWS));
        mover_code_c = mover_q ? 2'b10 : 2'b01;
    end

    // Run length for the direction under test this cycle.
    always_comb begin
        int dr;
        int dc;
        case (dir_q)
            2'd0:    begin dr = 0; dc = 1;  end
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        run_cnt_c = line_len(board_q, int'(row_q), int'(col_q), dr, dc, mover_code_c);
    end

    // Next-state and datapath.
    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        height_d = height_q;
        moves_d  = moves_q;
        col_d    = col_q;
        row_d    = row_q;
        mover_d  = mover_q;
        dir_d    = dir_q;
        win_d    = win_q;
        rej_d    = rej_q;
        busy_d   = busy_q;
        ack_d    = 1'b0;
        reject_d = 1'b0;
        turn_d   = turn_q;
        status_d = status_q;

        if (new_game) begin
            state_d  = S_IDLE;
            board_d  = '0;
            height_d = '0;
            moves_d  = '0;
            dir_d    = '0;
            win_d    = 1'b0;
            rej_d    = 1'b0;
            busy_d   = 1'b0;
            turn_d   = 1'b0;
            status_d = 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (move_valid) begin
                        if (status_q == 2'b00) begin
                            col_d   = move_col;
                            mover_d = turn_q;
                            win_d   = 1'b0;
                            rej_d   = 1'b0;
                            busy_d  = 1'b1;
                            state_d = S_DROP;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                end
                S_DROP: begin
                    if (!col_ok_c || col_full_c) begin
                        rej_d   = 1'b1;
                        state_d = S_REPORT;
                    end else begin
                        for (int r = 0; r < int'(ROWS); r++) begin
                            for (int c = 0; c < int'(COLS); c++) begin
                                if (HW'(r) == cur_height_c && 3'(c) == col_q) begin
                                    board_d[r][c] = mover_code_c;
                                end
                            end
                        end
                        for (int c = 0; c < int'(COLS); c++) begin
                            if (3'(c) == col_q) begin
                                height_d[c] = height_q[c] + HW'(1);
                            end
                        end
                        moves_d = moves_q + MW'(1);
                        row_d   = 3'(cur_height_c);
                        dir_d   = 2'd0;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (run_cnt_c >= 4) begin
                        win_d = 1'b1;
                    end
                    dir_d = dir_q + 2'd1;
                    if (dir_q == 2'd3) begin
                        state_d = S_REPORT;
                    end
                end
                S_REPORT: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    if (rej_q) begin
                        reject_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                        // Win outranks draw when the last cell completes a line.
                        if (win_q) begin
                            status_d = mover_q ? 2'b10 : 2'b01;
                        end else if (moves_q == MW'(CELLS)) begin
                            status_d = 2'b11;
                        end else begin
                            turn_d = ~turn_q;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            board_q  <= '0;
            height_q <= '0;
            moves_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            mover_q  <= 1'b0;
            dir_q    <= '0;
            win_q    <= 1'b0;
            rej_q    <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            reject_q <= 1'b0;
            turn_q   <= 1'b0;
            status_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            height_q <= height_d;
            moves_q  <= moves_d;
            col_q    <= col_d;
            row_q    <= row_d;
            mover_q  <= mover_d;
            dir_q    <= dir_d;
            win_q    <= win_d;
            rej_q    <= rej_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            reject_q <= reject_d;
            turn_q   <= turn_d;
            status_q <= status_d;
        end
    end

    // Display read port.
    always_comb begin
        rd_cell = 2'b00;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                if (3'(r) == rd_row && 3'(c) == rd_col) begin
                    rd_cell = board_q[r][c];
                end
            end
        end
    end

    assign busy        = busy_q;
    assign move_ack    = ack_q;
    assign move_reject = reject_q;
    assign player_turn = turn_q;
    assign game_status = status_q;

endmodule

// File: tb/tb_connect4_board_judge.sv
// Directed bench for connect4_board_judge (6x7 board).
module tb_connect4_board_judge;

    logic       clk;
    logic       reset;
    logic       new_game;
    logic       move_valid;
    logic [2:0] move_col;
    logic       busy;
    logic       move_ack;
    logic       move_reject;
    logic       player_turn;
    logic [1:0] game_status;
    logic [2:0] rd_row;
    logic [2:0] rd_col;
    logic [1:0] rd_cell;

    int n_vec = 0;
    int n_err = 0;

    localparam int K_ACK = 2;
    localparam int K_REJ = 1;

    connect4_board_judge #(.ROWS(6), .COLS(7)) dut (
        .clk         (clk),
        .reset       (reset),
        .new_game    (new_game),
        .move_valid  (move_valid),
        .move_col    (move_col),
        .busy        (busy),
        .move_ack    (move_ack),
        .move_reject (move_reject),
        .player_turn (player_turn),
        .game_status (game_status),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_cell     (rd_cell)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic read_cell(input int r, input int c, output logic [1:0] v);
        rd_row = 3'(r);
        rd_col = 3'(c);
        #1;
        v = rd_cell;
    endtask

    task automatic cell_is(input string tag, input int r, input int c, input int exp);
        logic [1:0] v;
        read_cell(r, c, v);
        check(tag, 32'(v), 32'(exp));
    endtask

    // Issue one request and measure cycles from the sampling edge to the pulse.
    task automatic do_move(input int col, input int exp_lat, input int exp_kind, input string tag);
        int lat;
        int kind;
        lat  = -1;
        kind = 0;
        @(negedge clk);
        move_valid = 1'b1;
        move_col   = 3'(col);
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), (exp_lat == 0) ? 32'd0 : 32'd1);
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (move_ack || move_reject) begin
                lat  = i;
                kind = {30'd0, move_ack, move_reject};
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_kind"}, 32'(kind), 32'(exp_kind));
        @(posedge clk);
        #1;
        check({tag, "_width"}, {30'd0, move_ack, move_reject}, 32'd0);
    endtask

    task automatic start_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    // Watch a window of cycles for stray result pulses.
    task automatic no_pulses(input string tag);
        int pulses;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (move_ack || move_reject) pulses++;
        end
        check(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int nz;
        logic [1:0] v;
        int pair_a[3] = '{0, 1, 4};
        int pair_b[3] = '{2, 3, 6};
        int sel[12]   = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};

        reset      = 1'b1;
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_col   = 3'd0;
        rd_row     = 3'd0;
        rd_col     = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_ack",    32'(move_ack), 32'd0);
        check("rst_rej",    32'(move_reject), 32'd0);
        check("rst_turn",   32'(player_turn), 32'd0);
        check("rst_status", 32'(game_status), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cell_is("rst_cell", 0, 0, 0);

        // Vertical win for player 0 in column 3.
        for (int m = 0; m < 7; m++) begin
            do_move((m % 2 == 0) ? 3 : 4, 6, K_ACK, "vert");
        end
        check("vert_status", 32'(game_status), 32'd1);
        check("vert_turn",   32'(player_turn), 32'd0);
        cell_is("vert_c33", 3, 3, 1);
        cell_is("vert_c24", 2, 4, 2);
        cell_is("vert_c34", 3, 4, 0);
        do_move(0, 0, K_REJ, "over");
        cell_is("over_c00", 0, 0, 0);
        check("over_status", 32'(game_status), 32'd1);

        // Fill column 0, then overflow it.
        start_new_game();
        check("ng_status", 32'(game_status), 32'd0);
        for (int m = 0; m < 6; m++) begin
            do_move(0, 6, K_ACK, "fill");
        end
        check("fill_status", 32'(game_status), 32'd0);
        check("fill_turn",   32'(player_turn), 32'd0);
        do_move(0, 2, K_REJ, "full");
        check("full_turn", 32'(player_turn), 32'd0);
        cell_is("full_c50", 5, 0, 2);
        cell_is("full_c40", 4, 0, 1);

        // Column index past the board edge.
        start_new_game();
        do_move(7, 2, K_REJ, "oor");
        nz = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                read_cell(r, c, v);
                if (v != 2'b00) nz++;
            end
        end
        check("oor_cells", 32'(nz), 32'd0);
        check("oor_turn",  32'(player_turn), 32'd0);

        // Rising diagonal for player 1, completed at (3,3).
        start_new_game();
        begin
            int seq[10] = '{1, 0, 2, 1, 3, 2, 3, 2, 3, 3};
            for (int m = 0; m < 10; m++) begin
                do_move(seq[m], 6, K_ACK, "rdiag");
                if (m == 8) check("rdiag_mid", 32'(game_status), 32'd0);
            end
        end
        check("rdiag_status", 32'(game_status), 32'd2);
        check("rdiag_turn",   32'(player_turn), 32'd1);

        // Falling diagonal for player 1, completed at middle cell (2,4).
        start_new_game();
        begin
            int seq[12] = '{5, 6, 4, 5, 3, 4, 3, 0, 3, 3, 0, 4};
            for (int m = 0; m < 12; m++) begin
                do_move(seq[m], 6, K_ACK, "fdiag");
            end
        end
        check("fdiag_status", 32'(game_status), 32'd2);
        check("fdiag_turn",   32'(player_turn), 32'd1);

        // Draw: columns pattern A A B B A A B, no line of four anywhere.
        start_new_game();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 12; i++) begin
                do_move((sel[i] == 1) ? pair_b[p] : pair_a[p], 6, K_ACK, "draw");
            end
        end
        check("draw_mid", 32'(game_status), 32'd0);
        for (int m = 0; m < 6; m++) begin
            do_move(5, 6, K_ACK, "draw");
        end
        check("draw_status", 32'(game_status), 32'd3);
        check("draw_turn",   32'(player_turn), 32'd1);
        do_move(0, 0, K_REJ, "draw_over");

        // Async reset during CHECK.
        start_new_game();
        do_move(2, 6, K_ACK, "pre_rst");
        @(negedge clk);
        move_valid = 1'b1;
        move_col   = 3'd2;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mrst_busy",   32'(busy), 32'd0);
        check("mrst_turn",   32'(player_turn), 32'd0);
        check("mrst_status", 32'(game_status), 32'd0);
        cell_is("mrst_c02", 0, 2, 0);
        cell_is("mrst_c12", 1, 2, 0);
        @(negedge clk);
        reset = 1'b0;
        no_pulses("mrst_quiet");
        do_move(2, 6, K_ACK, "post_rst");
        cell_is("post_rst_c02", 0, 2, 1);

        // new_game during CHECK.
        start_new_game();
        do_move(1, 6, K_ACK, "pre_ng");
        @(negedge clk);
        move_valid = 1'b1;
        move_col   = 3'd1;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        new_game = 1'b1;
        @(posedge clk);
        #1;
        new_game = 1'b0;
        check("mng_busy",   32'(busy), 32'd0);
        check("mng_turn",   32'(player_turn), 32'd0);
        check("mng_status", 32'(game_status), 32'd0);
        cell_is("mng_c01", 0, 1, 0);
        cell_is("mng_c11", 1, 1, 0);
        no_pulses("mng_quiet");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
